// File: rtl/maze_path_writer_if.sv
// Command channel into the maze path writer: valid/ready handshake plus
// the draw command fields.
interface maze_path_writer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [6:0] cmd_x;
   logic [6:0] cmd_y;
   logic [6:0] cmd_len;
   logic       cmd_val;

   modport master (
      output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_val,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_val,
      output cmd_ready
   );
endinterface

// File: rtl/maze_path_writer.sv
// Sole writer of the maze path bitmap read by the VGA renderer.
// Handles single-cell set/clear, horizontal/vertical run-length draws
// (clipped at the grid edge) and a row-per-cycle whole-grid clear.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ready for commands; cell ops complete here in one cycle
// ST_RUN   | writing one run cell per cycle at (cx, cy)
// ST_CLEAR | zeroing one full row per cycle, row counter row_q
module maze_path_writer #(
   parameter int GRID_W = 100,
   parameter int GRID_H = 100
) (
   input  logic                     clk,
   input  logic                     reset,
   maze_path_writer_if.slave        bus,
   input  logic                     clr_all,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [GRID_W*GRID_H-1:0] path_data
);

   localparam int               IDX_W = $clog2(GRID_W*GRID_H);
   localparam logic [7:0]       W8    = 8'(GRID_W);
   localparam logic [7:0]       H8    = 8'(GRID_H);
   localparam logic [IDX_W-1:0] W_IDX = IDX_W'(GRID_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Coordinates are 8 bits so that cx+1 at column 127 cannot wrap to 0.
   logic [7:0] cx_q, cy_q, row_q;
   logic [6:0] rem_q;
   logic       val_q, dir_q;
   logic       busy_q, done_q, err_q;

   logic             accept, in_range, run_last, row_last;
   logic             cell_wr, run_load, run_step, clr_start, clr_step;
   logic             done_d, err_d;
   logic [IDX_W-1:0] cell_idx, run_idx, row_base;

   assign bus.cmd_ready = (state_q == ST_IDLE) && !clr_all;
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign in_range      = ({1'b0, bus.cmd_x} < W8) && ({1'b0, bus.cmd_y} < H8);

   assign cell_idx = IDX_W'(bus.cmd_x) + W_IDX * IDX_W'(bus.cmd_y);
   assign run_idx  = IDX_W'(cx_q) + W_IDX * IDX_W'(cy_q);
   assign row_base = W_IDX * IDX_W'(row_q);

   // A run ends on its last requested cell or when the next step would leave the grid.
   assign run_last = (rem_q == 7'd1) ||
                     (dir_q ? ((cy_q + 8'd1) == H8) : ((cx_q + 8'd1) == W8));
   assign row_last = (row_q == (H8 - 8'd1));

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_d   = state_q;
      cell_wr   = 1'b0;
      run_load  = 1'b0;
      run_step  = 1'b0;
      clr_start = 1'b0;
      clr_step  = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (clr_all) begin
               clr_start = 1'b1;
               state_d   = ST_CLEAR;
            end else if (accept) begin
               if (!in_range) begin
                  err_d = 1'b1;
               end else if (!bus.cmd_op[1]) begin
                  cell_wr = 1'b1;
                  done_d  = 1'b1;
               end else if (bus.cmd_len == 7'd0) begin
                  done_d = 1'b1;
               end else begin
                  run_load = 1'b1;
                  state_d  = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            run_step = 1'b1;
            if (run_last) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            clr_step = 1'b1;
            if (row_last) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Status flags, registered so the renderer and game logic see clean pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= (state_d != ST_IDLE);
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   // Bitmap and run/clear counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         path_data <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         rem_q     <= '0;
         val_q     <= 1'b0;
         dir_q     <= 1'b0;
         row_q     <= '0;
      end else begin
         if (cell_wr) path_data[cell_idx] <= ~bus.cmd_op[0];
         if (run_load) begin
            cx_q  <= {1'b0, bus.cmd_x};
            cy_q  <= {1'b0, bus.cmd_y};
            rem_q <= bus.cmd_len;
            val_q <= bus.cmd_val;
            dir_q <= bus.cmd_op[0];
         end
         if (run_step) begin
            path_data[run_idx] <= val_q;
            if (dir_q) cy_q <= cy_q + 8'd1;
            else       cx_q <= cx_q + 8'd1;
            rem_q <= rem_q - 7'd1;
         end
         if (clr_start) row_q <= '0;
         if (clr_step) begin
            path_data[row_base +: GRID_W] <= '0;
            row_q <= row_q + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_maze_path_writer.sv
// Bench for maze_path_writer: directed scenarios plus random commands,
// checked against a bitmap model built from the drawing rules.
module tb_maze_path_writer;
   localparam int GW = 100;
   localparam int GH = 100;
   localparam int N  = GW * GH;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         clr_all = 1'b0;
   logic         busy, done, err;
   logic [N-1:0] path_data;
   logic [N-1:0] model;
   int           checks = 0;
   int           errors = 0;

   typedef struct {
      bit rdy;
      int busy_cyc;
      int ready_low;
      bit done_end;
      bit err_end;
      int extra;
      bit tmo;
      int e_busy;
      bit e_done;
      bit e_err;
   } res_t;

   maze_path_writer_if bus();

   maze_path_writer #(.GRID_W(GW), .GRID_H(GH)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .clr_all   (clr_all),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .path_data (path_data)
   );

   always #5 clk = ~clk;

   function automatic int first_diff(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [13:0] bi;
      for (int i = 0; i < N; i++) begin
         bi = 14'(i);
         if (a[bi] !== b[bi]) return i;
      end
      return -1;
   endfunction

   // Reference: apply a command to the model bitmap and predict handshake behaviour.
   task automatic model_cmd(input int op, input int x, input int y, input int len, input logic v,
                            output int e_busy, output bit e_done, output bit e_err);
      int n;
      logic [13:0] bi;
      e_busy = 0; e_done = 0; e_err = 0;
      if (x >= GW || y >= GH) begin
         e_err = 1;
      end else begin
         e_done = 1;
         if (op < 2) begin
            bi = 14'(x + GW * y);
            model[bi] = (op == 0);
         end else begin
            n = (op == 2) ? GW - x : GH - y;
            if (len < n) n = len;
            for (int k = 0; k < n; k++) begin
               bi = (op == 2) ? 14'(x + k + GW * y) : 14'(x + GW * (y + k));
               model[bi] = v;
            end
            e_busy = n;
         end
      end
   endtask

   // Drive one command, update the model, and watch the DUT until it is idle again.
   task automatic run_cmd(input int op, input int x, input int y, input int len, input logic v,
                          output res_t r);
      @(negedge clk);
      bus.cmd_op    = 2'(op);
      bus.cmd_x     = 7'(x);
      bus.cmd_y     = 7'(y);
      bus.cmd_len   = 7'(len);
      bus.cmd_val   = v;
      bus.cmd_valid = 1'b1;
      #1 r.rdy = bus.cmd_ready;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      model_cmd(op, x, y, len, v, r.e_busy, r.e_done, r.e_err);
      r.busy_cyc = 0; r.ready_low = 0; r.extra = 0; r.tmo = 0;
      for (int i = 0; i < 300 && busy; i++) begin
         r.busy_cyc++;
         if (!bus.cmd_ready) r.ready_low++;
         if (done || err) r.extra++;
         @(posedge clk); #1;
      end
      if (busy) r.tmo = 1;
      r.done_end = done;
      r.err_end  = err;
      if (!bus.cmd_ready) r.ready_low++;
      @(posedge clk); #1;
      if (done || err) r.extra++;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (path_data !== '0) begin errors++; $display("FAIL reset path_data: first set bit %0d, want all zero", first_diff(path_data, '0)); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready: got %b want 1", bus.cmd_ready); end
      @(negedge clk);
      reset = 1'b1;
      model = '0;
   endtask

   task automatic test_cell();
      res_t r;
      run_cmd(0, 3, 2, 0, 1'b0, r);
      checks++; if (path_data[203] !== 1'b1) begin errors++; $display("FAIL cell bit203: got %b want 1", path_data[203]); end
      checks++; if (path_data !== model) begin errors++; $display("FAIL cell bitmap: first diff at bit %0d", first_diff(path_data, model)); end
      checks++; if (r.done_end !== 1'b1 || r.busy_cyc !== 0) begin errors++; $display("FAIL cell done/busy: got done=%b busy_cycles=%0d want done=1 busy_cycles=0", r.done_end, r.busy_cyc); end
      checks++; if (r.extra !== 0 || r.err_end !== 1'b0) begin errors++; $display("FAIL cell pulse: got extra=%0d err=%b want 0/0", r.extra, r.err_end); end
   endtask

   task automatic test_hrun_clip();
      res_t r;
      run_cmd(2, 95, 0, 10, 1'b1, r);
      checks++; if (r.busy_cyc !== 5 || r.ready_low !== 5) begin errors++; $display("FAIL hrun busy: got busy=%0d ready_low=%0d want 5/5", r.busy_cyc, r.ready_low); end
      checks++; if (path_data[99:95] !== 5'b11111 || path_data[100] !== 1'b0) begin errors++; $display("FAIL hrun bits: got %b/%b want 11111/0", path_data[99:95], path_data[100]); end
      checks++; if (path_data !== model) begin errors++; $display("FAIL hrun bitmap: first diff at bit %0d", first_diff(path_data, model)); end
      checks++; if (r.done_end !== 1'b1 || r.extra !== 0 || r.tmo) begin errors++; $display("FAIL hrun done: got done=%b extra=%0d tmo=%b want 1/0/0", r.done_end, r.extra, r.tmo); end
   endtask

   task automatic test_vrun_then_clear();
      res_t r;
      run_cmd(3, 4, 10, 3, 1'b1, r);
      checks++; if (r.busy_cyc !== 3 || r.ready_low !== 3) begin errors++; $display("FAIL vrun busy: got busy=%0d ready_low=%0d want 3/3", r.busy_cyc, r.ready_low); end
      checks++; if (r.done_end !== 1'b1 || r.extra !== 0) begin errors++; $display("FAIL vrun done: got done=%b extra=%0d want 1/0", r.done_end, r.extra); end
      run_cmd(1, 4, 11, 0, 1'b0, r);
      checks++; if ({path_data[1004], path_data[1104], path_data[1204]} !== 3'b101) begin errors++; $display("FAIL vrun bits: got %b%b%b want 101", path_data[1004], path_data[1104], path_data[1204]); end
      checks++; if (path_data !== model) begin errors++; $display("FAIL vrun bitmap: first diff at bit %0d", first_diff(path_data, model)); end
   endtask

   task automatic test_errors();
      res_t r;
      run_cmd(0, 100, 5, 0, 1'b0, r);
      checks++; if (r.err_end !== 1'b1 || r.done_end !== 1'b0) begin errors++; $display("FAIL err x100: got err=%b done=%b want 1/0", r.err_end, r.done_end); end
      checks++; if (r.ready_low !== 0 || r.busy_cyc !== 0) begin errors++; $display("FAIL err ready: got ready_low=%0d busy=%0d want 0/0", r.ready_low, r.busy_cyc); end
      run_cmd(3, 7, 127, 5, 1'b1, r);
      checks++; if (r.err_end !== 1'b1 || r.done_end !== 1'b0 || r.extra !== 0) begin errors++; $display("FAIL err y127: got err=%b done=%b extra=%0d want 1/0/0", r.err_end, r.done_end, r.extra); end
      run_cmd(2, 20, 20, 0, 1'b1, r);
      checks++; if (r.done_end !== 1'b1 || r.err_end !== 1'b0 || r.busy_cyc !== 0) begin errors++; $display("FAIL len0: got done=%b err=%b busy=%0d want 1/0/0", r.done_end, r.err_end, r.busy_cyc); end
      checks++; if (path_data !== model) begin errors++; $display("FAIL err bitmap: first diff at bit %0d", first_diff(path_data, model)); end
   endtask

   task automatic test_random();
      res_t r;
      int op, x, y, len;
      logic v;
      for (int n = 0; n < 60; n++) begin
         op  = int'($urandom_range(0, 3));
         x   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 99));
         y   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 99));
         len = int'($urandom_range(0, 40));
         v   = 1'($urandom_range(0, 1));
         run_cmd(op, x, y, len, v, r);
         checks++; if (r.rdy !== 1'b1) begin errors++; $display("FAIL rand[%0d] ready at send: got %b want 1", n, r.rdy); end
         checks++; if (r.busy_cyc !== r.e_busy || r.ready_low !== r.e_busy || r.tmo) begin errors++; $display("FAIL rand[%0d] busy: got %0d ready_low=%0d want %0d (op=%0d x=%0d y=%0d len=%0d)", n, r.busy_cyc, r.ready_low, r.e_busy, op, x, y, len); end
         checks++; if (r.done_end !== r.e_done || r.err_end !== r.e_err || r.extra !== 0) begin errors++; $display("FAIL rand[%0d] pulses: got done=%b err=%b extra=%0d want %b/%b/0", n, r.done_end, r.err_end, r.extra, r.e_done, r.e_err); end
         checks++; if (path_data !== model) begin errors++; $display("FAIL rand[%0d] bitmap: first diff at bit %0d (op=%0d x=%0d y=%0d len=%0d)", n, first_diff(path_data, model), op, x, y, len); end
      end
   endtask

   task automatic test_back_to_back();
      int x, y, px, py, pop;
      logic [13:0] bi;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = 7'd0;
      bus.cmd_val   = 1'b0;
      px = int'($urandom_range(0, 99)); py = int'($urandom_range(0, 99)); pop = int'($urandom_range(0, 1));
      bus.cmd_op = 2'(pop); bus.cmd_x = 7'(px); bus.cmd_y = 7'(py);
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         bi = 14'(px + GW * py);
         model[bi] = (pop == 0);
         checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d] status: got done=%b busy=%b ready=%b want 1/0/1", n, done, busy, bus.cmd_ready); end
         checks++; if (path_data !== model) begin errors++; $display("FAIL b2b[%0d] bitmap: first diff at bit %0d", n, first_diff(path_data, model)); end
         x = int'($urandom_range(0, 99)); y = int'($urandom_range(0, 99));
         px = x; py = y; pop = int'($urandom_range(0, 1));
         bus.cmd_op = 2'(pop); bus.cmd_x = 7'(px); bus.cmd_y = 7'(py);
      end
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_clear_all();
      res_t r;
      int cyc, early;
      for (int row = 0; row < GH; row++) run_cmd(2, 0, row, 100, 1'b1, r);
      checks++; if (path_data !== model || model !== {N{1'b1}}) begin errors++; $display("FAIL fill bitmap: first diff at bit %0d", first_diff(path_data, {N{1'b1}})); end
      @(negedge clk);
      clr_all = 1'b1;
      bus.cmd_op = 2'b01; bus.cmd_x = 7'd7; bus.cmd_y = 7'd7; bus.cmd_len = 7'd0;
      bus.cmd_valid = 1'b1;
      #1;
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL clr ready with clr_all: got %b want 0", bus.cmd_ready); end
      @(posedge clk); #1;
      clr_all = 1'b0;
      bus.cmd_valid = 1'b0;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL clr start: got busy=%b done=%b want 1/0", busy, done); end
      cyc = 0; early = 0;
      for (int i = 0; i < 300 && busy; i++) begin
         cyc++;
         if (cyc == 50) begin
            checks++; if (path_data[48*GW +: GW] !== '0 || path_data[49*GW +: GW] !== {GW{1'b1}}) begin errors++; $display("FAIL clr partial: row48 ones=%0d row49 ones=%0d want 0/100", $countones(path_data[48*GW +: GW]), $countones(path_data[49*GW +: GW])); end
            clr_all = 1'b1;
         end
         if (cyc == 51) clr_all = 1'b0;
         if (done || err) early++;
         @(posedge clk); #1;
      end
      model = '0;
      checks++; if (cyc !== 100 || early !== 0) begin errors++; $display("FAIL clr length: got busy=%0d early_pulses=%0d want 100/0", cyc, early); end
      checks++; if (done !== 1'b1 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL clr done: got done=%b ready=%b want 1/1", done, bus.cmd_ready); end
      checks++; if (path_data !== '0) begin errors++; $display("FAIL clr bitmap: first set bit %0d", first_diff(path_data, '0)); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clr after: got done=%b busy=%b want 0/0", done, busy); end
   endtask

   task automatic test_reset_mid_run();
      res_t r;
      @(negedge clk);
      bus.cmd_op = 2'b10; bus.cmd_x = 7'd0; bus.cmd_y = 7'd5; bus.cmd_len = 7'd20; bus.cmd_val = 1'b1;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (path_data[503:500] !== 4'b0111 || busy !== 1'b1) begin errors++; $display("FAIL midrun partial: got bits=%b busy=%b want 0111/1", path_data[503:500], busy); end
      #2 reset = 1'b0;
      #1;
      checks++; if (path_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrun reset: ones=%0d busy=%b done=%b want 0/0/0", $countones(path_data), busy, done); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrun ready: got %b want 1", bus.cmd_ready); end
      model = '0;
      @(negedge clk);
      reset = 1'b1;
      run_cmd(0, 10, 10, 0, 1'b0, r);
      checks++; if (r.rdy !== 1'b1 || r.done_end !== 1'b1 || r.busy_cyc !== 0) begin errors++; $display("FAIL postreset cmd: got rdy=%b done=%b busy=%0d want 1/1/0", r.rdy, r.done_end, r.busy_cyc); end
      checks++; if (path_data !== model || path_data[1010] !== 1'b1) begin errors++; $display("FAIL postreset bitmap: first diff at bit %0d", first_diff(path_data, model)); end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_x     = 7'd0;
      bus.cmd_y     = 7'd0;
      bus.cmd_len   = 7'd0;
      bus.cmd_val   = 1'b0;
      model         = '0;
      test_reset();
      test_cell();
      test_hrun_clip();
      test_vrun_then_clear();
      test_errors();
      test_random();
      test_back_to_back();
      test_clear_all();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/maze_path_writer.md
# maze_path_writer

Command-driven writer for the maze path bitmap consumed by the VGA maze renderer. Accepts single-cell and run-length draw commands plus a whole-grid clear over a valid/ready handshake. Maintains the registered flat bitmap `path_data`, where bit index is `x + GRID_W*y` and a 1 marks a path cell. Sits between maze generation/game logic and the renderer. The renderer only reads the bitmap; this block is the sole writer.

## Interface
- `GRID_W`, 100, grid columns; bitmap row stride.
- `GRID_H`, 100, grid rows.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  combinational: `(state==IDLE) && !clr_all`.
- `cmd_op`  in  2  00 set cell, 01 clear cell, 10 horizontal run, 11 vertical run.
- `cmd_x`  in  7  start column.
- `cmd_y`  in  7  start row.
- `cmd_len`  in  7  run length in cells; used by runs only.
- `cmd_val`  in  1  value written by runs.
- `clr_all`  in  1  request to clear the whole grid; sampled in IDLE only.
- `busy`  out  1  registered, `state != IDLE`.
- `done`  out  1  registered, one-cycle pulse on command completion.
- `err`  out  1  registered, one-cycle pulse on a rejected command.
- `path_data`  out  GRID_W*GRID_H  registered bitmap.

## Operation
- **States:** IDLE, RUN, CLEAR.
- **Accept:** a command is accepted on a rising edge with `cmd_valid && cmd_ready`.
- **Range check at accept:**
  - If `cmd_x >= GRID_W` or `cmd_y >= GRID_H`: no bitmap change, `err` pulses, no `done`, stay IDLE.
- **Set/clear cell (op 00/01):**
  - Bit `cmd_x + GRID_W*cmd_y` is written 1 or 0 on the accept edge.
  - Stay IDLE, so back-to-back cell commands run at one per cycle.
- **Run (op 10/11) with `cmd_len == 0`:** no-op; `done` pulses; stay IDLE.
- **Run (op 10/11) with `cmd_len > 0`:**
  - On accept, latch `cx=cmd_x`, `cy=cmd_y`, `rem=cmd_len`, `val=cmd_val`, `dir=cmd_op[0]`; go to RUN.
  - Each RUN cycle writes `val` at `(cx,cy)`, then advances `cx` (horizontal) or `cy` (vertical) and decrements `rem`.
  - Leave RUN after the write where `rem==1`, or where the next coordinate would reach `GRID_W`/`GRID_H` (clip at the grid edge, no wrap). Then return to IDLE and pulse `done`.
  - A clipped run is not an error.
- **Clear all:**
  - `clr_all` high in IDLE takes priority: any same-cycle `cmd_valid` is not accepted because `cmd_ready` is low.
  - Go to CLEAR with row counter 0. Each cycle zeroes all `GRID_W` bits of the current row.
  - After row `GRID_H-1`, return to IDLE and pulse `done`.
  - `clr_all` is ignored in RUN and CLEAR.
- **Width rules:**
  - Coordinate arithmetic is 8 bits wide so that `cx+1` cannot wrap 127 to 0.
  - Index math is `x + GRID_W*y` in at least 14 bits.
- **Reset (asynchronous, any time, including mid-RUN/CLEAR):**
  - `path_data` = all zeros; state = IDLE.
  - `busy`=0, `done`=0, `err`=0; all latched counters = 0.
  - `cmd_ready` follows its equation, i.e. it reads 1 when `clr_all` is low.
  - A run in progress is abandoned; its already-written cells are lost with the reset.

## Timing
- **Cell op:** bitmap bit updated at the accept edge and visible on `path_data` the following cycle; `done` high for the cycle after accept.
- **Run of L cells (unclipped), accept at edge 0:**
  - Cells written at edges 1..L.
  - `busy` is high from edge 0 to edge L.
  - `done` is high in the cycle after edge L, the same cycle `cmd_ready` returns high.
  - A clipped run ends after `GRID_W-x` or `GRID_H-y` writes.
- **Clear:** `clr_all` sampled at edge 0; rows cleared at edges 1..GRID_H; `done` high after edge GRID_H. Total 101 cycles at defaults.
- **Error:** `err` high for the cycle after the rejecting edge; `cmd_ready` stays high.
- `done` and `err` are never high together.
- The renderer may read `path_data` at any time. Partially drawn runs and partial clears are visible; this is acceptable.

## Test plan
- Reset, then set cell (3,2) → next cycle `path_data[203]=1`, `done`=1 for 1 cycle, all other bits 0.
- Horizontal run x=95, y=0, len=10, val=1 → bits 95..99 set, bit 100 untouched, `busy` high for 5 cycles, one `done` pulse.
- Vertical run x=4, y=10, len=3, val=1, then clear cell (4,11) → bits 1004 and 1204 = 1, bit 1104 = 0; `cmd_ready` low exactly during the run.
- Cell command with x=100 → no bitmap change, `err` pulse, no `done`. Run with len=0 → `done` pulse, no change.
- Fill the grid, then raise `clr_all` together with `cmd_valid` → command not accepted, 100 clear cycles, all bits 0, `done` on cycle 101. Re-pulsing `clr_all` mid-clear has no effect.
- Assert `reset` low mid-run (after 3 of 20 writes) → `path_data`=0 and `busy`=0 immediately. After release, a new command is accepted normally.
